mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) single-memory arbiter, ARB_ROUND_ROBIN_EN selects round-robin ties
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_gnt,
    output logic        f_done,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]  state;
    logic        owner_data;
    logic        lat_we;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [15:0] f_rdata_q;
    logic [15:0] d_rdata_q;

    logic f_elig;
    logic d_elig;
    logic can_grant;
    logic grant;
    logic pick_data;
    logic in_done;
    logic read_done;

    assign in_done   = (state == ST_DONE);
    assign read_done = in_done && !lat_we;

    // The port just being completed cannot win again in its own DONE cycle.
    assign f_elig    = f_req && !(in_done && !owner_data);
    assign d_elig    = d_req && !(in_done && owner_data);
    assign can_grant = (state == ST_IDLE) || in_done;
    assign grant     = can_grant && (f_elig || d_elig);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_data <= 1'b0;
        end else if (grant) begin
            last_data <= pick_data;
        end
    end

    assign pick_data = (f_elig && d_elig) ? !last_data : d_elig;
`else
    assign pick_data = d_elig;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner_data <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= 16'h0000;
            lat_wdata  <= 16'h0000;
            f_rdata_q  <= 16'h0000;
            d_rdata_q  <= 16'h0000;
        end else begin
            if (read_done) begin
                if (owner_data) begin
                    d_rdata_q <= mem_rdata;
                end else begin
                    f_rdata_q <= mem_rdata;
                end
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (grant) begin
                        state      <= ST_ACCESS;
                        owner_data <= pick_data;
                        lat_we     <= pick_data ? d_we : 1'b0;
                        lat_addr   <= pick_data ? d_addr : f_addr;
                        if (pick_data) begin
                            lat_wdata <= d_wdata;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: state <= ST_DONE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign f_gnt     = busy && !owner_data;
    assign d_gnt     = busy && owner_data;
    assign mem_en    = (state == ST_ACCESS);
    assign mem_we    = mem_en && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign f_done    = in_done && !owner_data;
    assign d_done    = in_done && owner_data;

    // Read data is forwarded in the DONE cycle itself and held afterwards.
    assign f_rdata = (read_done && !owner_data) ? mem_rdata : f_rdata_q;
    assign d_rdata = (read_done && owner_data) ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_we;
    logic [15:0] f_addr, d_addr, d_wdata, mem_rdata;
    logic        f_gnt, f_done, d_gnt, d_done, mem_en, mem_we, busy;
    logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = no access, 1 = memory strobe cycle, 2 = completion cycle.
    int          m_phase, m_own, m_last;
    logic        m_we;
    logic [15:0] m_addr, m_wdata, m_frd, m_drd;
    int          own_log[$];
    int          done_cycles[$];
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_grant(input logic fr, input logic dr);
        int w;
        if (!(fr || dr)) begin
            m_phase = 0;
        end else begin
            if (fr && dr) w = RR ? (m_last == 0 ? 1 : 0) : 1;
            else          w = dr ? 1 : 0;
            m_own  = w;
            m_we   = (w == 1) ? d_we : 1'b0;
            m_addr = (w == 1) ? d_addr : f_addr;
            if (w == 1) m_wdata = d_wdata;
            m_last  = w;
            m_phase = 1;
            own_log.push_back(w);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_phase = 0; m_own = 0; m_last = 0; m_we = 1'b0;
            m_addr = 16'h0; m_wdata = 16'h0; m_frd = 16'h0; m_drd = 16'h0;
        end else if (m_phase == 0) begin
            model_grant(f_req, d_req);
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            if (!m_we) begin
                if (m_own == 1) m_drd = mem_rdata;
                else            m_frd = mem_rdata;
            end
            model_grant(f_req && m_own != 0, d_req && m_own != 1);
        end
    endtask

    task automatic check_outputs();
        logic act, fin, rd;
        act = (m_phase != 0);
        fin = (m_phase == 2);
        rd  = fin && !m_we;
        check("busy", busy, act);
        check("f_gnt", f_gnt, act && m_own == 0);
        check("d_gnt", d_gnt, act && m_own == 1);
        check("gnt_excl", f_gnt & d_gnt, 1'b0);
        check("mem_en", mem_en, m_phase == 1);
        check("mem_we", mem_we, m_phase == 1 && m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("f_done", f_done, fin && m_own == 0);
        check("d_done", d_done, fin && m_own == 1);
        check("f_rdata", f_rdata, (rd && m_own == 0) ? mem_rdata : m_frd);
        check("d_rdata", d_rdata, (rd && m_own == 1) ? mem_rdata : m_drd);
        if (f_done || d_done) done_cycles.push_back(cyc);
    endtask

    task automatic step(input logic rst, input logic fr, input logic [15:0] fa,
                        input logic dr, input logic dwe, input logic [15:0] da,
                        input logic [15:0] dwd, input logic [15:0] mrd);
        @(negedge clk);
        reset = rst; f_req = fr; f_addr = fa; d_req = dr; d_we = dwe;
        d_addr = da; d_wdata = dwd; mem_rdata = mrd;
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    endtask

    logic f_pend, d_pend, fr, dr, r;

    initial begin
        reset = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0;
        m_phase = 0; m_own = 0; m_last = 0; m_we = 1'b0;
        m_addr = 16'h0; m_wdata = 16'h0; m_frd = 16'h0; m_drd = 16'h0;
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        idle_steps(1);

        // Single fetch read
        step(1'b0, 1'b1, 16'h3000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 16'h3000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 16'h3000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h5555);
        check("fetch_rdata_hold", f_rdata, 16'h1234);

        // Data write
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h4000, 16'hBEEF, 16'h0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h7777, 16'h1111, 16'h0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h7777, 16'h1111, 16'h9999);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        check("write_addr", mem_addr, 16'h4000);
        check("write_data", mem_wdata, 16'hBEEF);
        check("write_rdata_keep", d_rdata, 16'h0000);

        // Tie from reset: both held, expect strict alternation starting with data
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        own_log.delete();
        done_cycles.delete();
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0, 16'h0200, 16'h0, 16'(i));
        check("tie_grants", own_log.size(), 4);
        for (int i = 0; i < 4 && i < own_log.size(); i++)
            check("tie_owner", own_log[i], (i % 2 == 0) ? 1 : 0);
        check("tie_dones", done_cycles.size(), 3);
        for (int i = 1; i < done_cycles.size(); i++)
            check("tie_spacing", done_cycles[i] - done_cycles[i-1], 2);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

        // Reset while in ACCESS, then a normal fetch
        step(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        step(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0, 16'h0, 16'hAAAA);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", f_done, 1'b0);
        check("rst_rdata", f_rdata, 16'h0000);
        step(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0, 16'h0, 16'h4321);

        // Fetch req held one cycle past DONE: no second access
        own_log.delete();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        #1;
        check("held_busy", busy, 1'b0);
        check("held_regrant", own_log.size(), 0);
        check("held_rdata", f_rdata, 16'h4321);

        // Randomized traffic
        f_pend = 1'b0; d_pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 79) == 0);
            if (m_phase == 2 && m_own == 0) f_pend = 1'($urandom_range(0, 1));
            else if (!f_pend)               f_pend = ($urandom_range(0, 2) == 0);
            if (m_phase == 2 && m_own == 1) d_pend = 1'($urandom_range(0, 1));
            else if (!d_pend)               d_pend = ($urandom_range(0, 2) == 0);
            fr = (m_phase == 1 && m_own == 0) ? 1'($urandom_range(0, 1)) : f_pend;
            dr = (m_phase == 1 && m_own == 1) ? 1'($urandom_range(0, 1)) : d_pend;
            step(r, fr, 16'($urandom), dr, 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
